// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared types and constants for the score keeper
package score_keeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LOSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam int HITS_PER_WIN_MIN = 1;
  localparam int HITS_PER_WIN_MAX = 9;

  function automatic bit hits_in_range(int n);
    return (n >= HITS_PER_WIN_MIN) && (n <= HITS_PER_WIN_MAX);
  endfunction

endpackage

// File: rtl/score_keeper_digit.sv
// rtl/score_keeper_digit.sv - one BCD digit with clear, enable/carry-in and carry-out
module bcd_digit_counter
  import score_keeper_pkg::*;
#(
  parameter bcd_t LIMIT = BCD_MAX
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output bcd_t q,
  output logic carry
);

  // >= rather than == keeps the digit inside 0..LIMIT even from a corrupt value
  assign carry = en && (q >= LIMIT);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= (q >= LIMIT) ? '0 : q + 4'd1;
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - game state machine with BCD hit and win counters
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int HITS_PER_WIN = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  output logic [11:0] number_win,
  output logic        lose,
  output logic        playing,
  output logic        win_pulse
);

  generate
    if (!hits_in_range(HITS_PER_WIN)) begin : g_bad_hits_per_win
      $error("HITS_PER_WIN must be within 1..9");
    end
  endgenerate

  localparam bcd_t HIT_LIMIT = 4'(HITS_PER_WIN - 1);

  logic   start_s1, start_s2, start_d;
  logic   start_edge;
  state_t state;
  logic   count_clr, hit_en, hit_carry, win_en, units_carry, saturated;
  logic   unused_tens_carry;
  bcd_t   hit_q, units_q, tens_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
    end
  end

  assign start_edge = start_s2 & ~start_d;
  assign count_clr  = start_edge && (state != PLAY);
  // a miss in the same cycle swallows the hit
  assign hit_en     = (state == PLAY) && hit && !miss;
  assign saturated  = (tens_q == BCD_MAX) && (units_q == BCD_MAX);
  assign win_en     = hit_carry && !saturated;

  bcd_digit_counter #(.LIMIT(HIT_LIMIT)) u_hit_digit (
    .Clk(Clk), .Rst(Rst), .clr(count_clr), .en(hit_en), .q(hit_q), .carry(hit_carry)
  );

  bcd_digit_counter #(.LIMIT(BCD_MAX)) u_units_digit (
    .Clk(Clk), .Rst(Rst), .clr(count_clr), .en(win_en), .q(units_q), .carry(units_carry)
  );

  bcd_digit_counter #(.LIMIT(BCD_MAX)) u_tens_digit (
    .Clk(Clk), .Rst(Rst), .clr(count_clr), .en(units_carry), .q(tens_q),
    .carry(unused_tens_carry)
  );

  assign number_win = {tens_q, units_q, hit_q};

  // lose/playing are flops updated alongside the state so they never glitch
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      lose      <= 1'b0;
      playing   <= 1'b0;
      win_pulse <= 1'b0;
    end else begin
      win_pulse <= hit_carry;
      case (state)
        IDLE: if (start_edge) begin
          state   <= PLAY;
          playing <= 1'b1;
        end
        PLAY: if (miss) begin
          state   <= LOSE;
          playing <= 1'b0;
          lose    <= 1'b1;
        end
        LOSE: if (start_edge) begin
          state   <= PLAY;
          playing <= 1'b1;
          lose    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
          lose    <= 1'b0;
        end
      endcase
    end
  end

endmodule
